// File: rtl/varredura_matriz_leds_pkg.sv
// Shared constants for the LED matrix scanner.
// Contents:
//   NUM_COLUNAS / NUM_LINHAS  - physical matrix geometry (5 columns x 7 rows)
//   OCIOSO / CARGA / VARRE    - scanner FSM state encoding
//   COLUNAS_APAGADAS          - column drive with every column deselected (active-low)
//   LINHAS_APAGADAS           - row drive with every row off
package varredura_matriz_leds_pkg;

    localparam int unsigned NUM_COLUNAS = 5;
    localparam int unsigned NUM_LINHAS  = 7;

    localparam logic [1:0] OCIOSO = 2'd0;
    localparam logic [1:0] CARGA  = 2'd1;
    localparam logic [1:0] VARRE  = 2'd2;

    localparam logic [NUM_COLUNAS-1:0] COLUNAS_APAGADAS = '1;
    localparam logic [NUM_LINHAS-1:0]  LINHAS_APAGADAS  = '0;

endpackage

// File: rtl/varredura_matriz_leds_gerador_tick.sv
// Modulo-DIV free-running counter producing a one-cycle tick.
// Ports:
//   clock  - system clock
//   reset  - synchronous active-high reset (counter to 0)
//   clear  - synchronous clear (counter to 0), same priority as reset
//   enable - counter advances only while high
//   tick   - high on the cycle the counter equals DIV-1 while enabled
module gerador_tick #(
    parameter int unsigned DIV = 50000
) (
    input  logic clock,
    input  logic reset,
    input  logic clear,
    input  logic enable,
    output logic tick
);

    localparam int unsigned W = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [W-1:0] ULTIMO = W'(DIV - 1);

    logic [W-1:0] contador;

    assign tick = enable && (contador == ULTIMO);

    always_ff @(posedge clock) begin
        if (reset || clear) begin
            contador <= '0;
        end else if (enable) begin
            if (contador == ULTIMO) begin
                contador <= '0;
            end else begin
                contador <= contador + 1'b1;
            end
        end
    end

endmodule

// File: rtl/varredura_matriz_leds.sv
// Time-multiplexed 5x7 LED matrix scanner with per-frame snapshot and blinking cursor.
// Ports:
//   clock, reset              - system clock, synchronous active-high reset
//   enable                    - display on; low blanks outputs and parks the scanner
//   matriz0..matriz4          - column words (bit r = row r lit), sampled once per frame
//   coordColuna, coordLinha   - cursor position, sampled live
//   cursor_en                 - enables the blinking cursor overlay
//   colunas                   - one-hot active-low column drive (registered)
//   linhas                    - active-high row drive (registered)
//   frame_start               - one-cycle pulse when a new snapshot is taken
module varredura_matriz_leds
    import varredura_matriz_leds_pkg::*;
#(
    parameter int unsigned DIV          = 50000,
    parameter int unsigned BLINK_FRAMES = 25
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic                   enable,
    input  logic [NUM_LINHAS-1:0]  matriz0,
    input  logic [NUM_LINHAS-1:0]  matriz1,
    input  logic [NUM_LINHAS-1:0]  matriz2,
    input  logic [NUM_LINHAS-1:0]  matriz3,
    input  logic [NUM_LINHAS-1:0]  matriz4,
    input  logic [2:0]             coordColuna,
    input  logic [2:0]             coordLinha,
    input  logic                   cursor_en,
    output logic [NUM_COLUNAS-1:0] colunas,
    output logic [NUM_LINHAS-1:0]  linhas,
    output logic                   frame_start
);

    localparam logic [7:0] BLINK_ULTIMO = 8'(BLINK_FRAMES - 1);

    logic [1:0]            estado;
    logic [1:0]            estado_prox;
    logic [2:0]            col_idx;
    logic [NUM_LINHAS-1:0] buffer [NUM_COLUNAS];
    logic [7:0]            blink_cnt;
    logic                  blink_phase;
    logic                  tick;
    logic                  tick_en;
    logic                  tick_clear;
    logic                  fim_quadro;
    logic [NUM_LINHAS-1:0] cursor_mask;

    // The tick counter only runs while actively scanning; any other state
    // (or a dropping enable) holds it at zero so each column gets a full dwell.
    assign tick_en    = enable && (estado == VARRE);
    assign tick_clear = !tick_en;
    assign fim_quadro = tick && (col_idx == 3'd4);

    gerador_tick #(
        .DIV (DIV)
    ) u_gerador_tick (
        .clock  (clock),
        .reset  (reset),
        .clear  (tick_clear),
        .enable (tick_en),
        .tick   (tick)
    );

    always_comb begin
        estado_prox = estado;
        case (estado)
            OCIOSO:  if (enable) estado_prox = CARGA;
            CARGA:   estado_prox = VARRE;
            VARRE:   estado_prox = VARRE;
            default: estado_prox = OCIOSO;
        endcase
        if (!enable) begin
            estado_prox = OCIOSO;
        end
    end

    // Out-of-range coordinates simply never match, so they yield no overlay.
    always_comb begin
        cursor_mask = '0;
        if (cursor_en && blink_phase && (coordColuna == col_idx) &&
            (coordColuna <= 3'd4) && (coordLinha <= 3'd6)) begin
            cursor_mask = NUM_LINHAS'(1) << coordLinha;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            estado      <= OCIOSO;
            col_idx     <= '0;
            blink_cnt   <= '0;
            blink_phase <= 1'b0;
            frame_start <= 1'b0;
            colunas     <= COLUNAS_APAGADAS;
            linhas      <= LINHAS_APAGADAS;
            for (int i = 0; i < NUM_COLUNAS; i++) begin
                buffer[i] <= '0;
            end
        end else begin
            estado      <= estado_prox;
            frame_start <= 1'b0;

            if (!enable || (estado == OCIOSO)) begin
                // Parked: a later re-enable restarts cleanly with blink cleared.
                col_idx     <= '0;
                blink_cnt   <= '0;
                blink_phase <= 1'b0;
            end else if (estado == CARGA) begin
                buffer      <= '{matriz0, matriz1, matriz2, matriz3, matriz4};
                col_idx     <= '0;
                frame_start <= 1'b1;
            end else if (tick) begin
                if (fim_quadro) begin
                    buffer      <= '{matriz0, matriz1, matriz2, matriz3, matriz4};
                    col_idx     <= '0;
                    frame_start <= 1'b1;
                    if (blink_cnt == BLINK_ULTIMO) begin
                        blink_cnt   <= '0;
                        blink_phase <= !blink_phase;
                    end else begin
                        blink_cnt <= blink_cnt + 1'b1;
                    end
                end else begin
                    col_idx <= col_idx + 1'b1;
                end
            end

            // Drive from the snapshot only; blank whenever not scanning.
            if (enable && (estado == VARRE)) begin
                colunas <= ~(NUM_COLUNAS'(1) << col_idx);
                linhas  <= buffer[col_idx] ^ cursor_mask;
            end else begin
                colunas <= COLUNAS_APAGADAS;
                linhas  <= LINHAS_APAGADAS;
            end
        end
    end

endmodule

// File: tb/tb_varredura_matriz_leds.sv
// Directed self-checking bench for varredura_matriz_leds with DIV=4, BLINK_FRAMES=2.
// Outputs are sampled on the falling edge; inputs change right after sampling.
module tb_varredura_matriz_leds;

    localparam int unsigned DIV          = 4;
    localparam int unsigned BLINK_FRAMES = 2;

    logic       clock = 1'b0;
    logic       reset;
    logic       enable;
    logic [6:0] matriz0, matriz1, matriz2, matriz3, matriz4;
    logic [2:0] coordColuna, coordLinha;
    logic       cursor_en;
    logic [4:0] colunas;
    logic [6:0] linhas;
    logic       frame_start;

    int checks   = 0;
    int failures = 0;

    always #5 clock = ~clock;

    varredura_matriz_leds #(
        .DIV          (DIV),
        .BLINK_FRAMES (BLINK_FRAMES)
    ) dut (
        .clock       (clock),
        .reset       (reset),
        .enable      (enable),
        .matriz0     (matriz0),
        .matriz1     (matriz1),
        .matriz2     (matriz2),
        .matriz3     (matriz3),
        .matriz4     (matriz4),
        .coordColuna (coordColuna),
        .coordLinha  (coordLinha),
        .cursor_en   (cursor_en),
        .colunas     (colunas),
        .linhas      (linhas),
        .frame_start (frame_start)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_blank(input string tag, input logic exp_fs);
        check({tag, " colunas"}, {27'b0, colunas}, 32'h1f);
        check({tag, " linhas"}, {25'b0, linhas}, 32'h0);
        check({tag, " frame_start"}, {31'b0, frame_start}, {31'b0, exp_fs});
    endtask

    // One full frame starting on the sample right after a snapshot edge:
    // each column for DIV samples, frame_start only on the very last sample.
    task automatic check_frame(input string tag, input logic [6:0] l0, input logic [6:0] l1,
                               input logic [6:0] l2, input logic [6:0] l3,
                               input logic [6:0] l4);
        logic [6:0] lin [5];
        logic [4:0] exp_col;
        logic       exp_fs;
        lin = '{l0, l1, l2, l3, l4};
        for (int c = 0; c < 5; c++) begin
            for (int s = 0; s < int'(DIV); s++) begin
                @(negedge clock);
                exp_col = ~(5'b00001 << c);
                exp_fs  = (c == 4) && (s == int'(DIV) - 1);
                check($sformatf("%s c%0d s%0d colunas", tag, c, s), {27'b0, colunas},
                      {27'b0, exp_col});
                check($sformatf("%s c%0d s%0d linhas", tag, c, s), {25'b0, linhas},
                      {25'b0, lin[c]});
                check($sformatf("%s c%0d s%0d frame_start", tag, c, s),
                      {31'b0, frame_start}, {31'b0, exp_fs});
            end
        end
    endtask

    initial begin
        #50000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        reset       = 1'b1;
        enable      = 1'b0;
        matriz0     = '0;
        matriz1     = '0;
        matriz2     = '0;
        matriz3     = '0;
        matriz4     = '0;
        coordColuna = '0;
        coordLinha  = '0;
        cursor_en   = 1'b0;
        repeat (2) @(negedge clock);
        check_blank("reset", 1'b0);

        // Start: OCIOSO -> CARGA -> VARRE, frame_start two edges after enable.
        reset   = 1'b0;
        enable  = 1'b1;
        matriz0 = 7'b1110001;
        @(negedge clock);
        check_blank("start+1", 1'b0);
        @(negedge clock);
        check_blank("start+2", 1'b1);
        check_frame("f1", 7'b1110001, 7'b0, 7'b0, 7'b0, 7'b0);

        // Column 0 is current; a change to matriz1 waits for the next snapshot.
        matriz1 = 7'b0100000;
        check_frame("f2_old", 7'b1110001, 7'b0, 7'b0, 7'b0, 7'b0);
        matriz4 = 7'b1110000;
        check_frame("f3_new", 7'b1110001, 7'b0100000, 7'b0, 7'b0, 7'b0);

        // Blink phase is 1 here, but column 5 is out of range: no overlay.
        cursor_en   = 1'b1;
        coordColuna = 3'd5;
        coordLinha  = 3'd6;
        check_frame("f4_col5", 7'b1110001, 7'b0100000, 7'b0, 7'b0, 7'b1110000);
        coordColuna = 3'd4;
        check_frame("f5_off", 7'b1110001, 7'b0100000, 7'b0, 7'b0, 7'b1110000);
        check_frame("f6_off", 7'b1110001, 7'b0100000, 7'b0, 7'b0, 7'b1110000);
        check_frame("f7_on", 7'b1110001, 7'b0100000, 7'b0, 7'b0, 7'b0110000);

        // Drop enable mid-frame while blink_phase is 1.
        repeat (6) @(negedge clock);
        enable = 1'b0;
        @(negedge clock);
        check_blank("disable+1", 1'b0);
        repeat (2) @(negedge clock);
        check_blank("disable+3", 1'b0);
        enable = 1'b1;
        @(negedge clock);
        check_blank("reen+1", 1'b0);
        @(negedge clock);
        check_blank("reen+2", 1'b1);
        // Blink state cleared: two frames without overlay.
        check_frame("f9_reen", 7'b1110001, 7'b0100000, 7'b0, 7'b0, 7'b1110000);
        check_frame("f10_reen", 7'b1110001, 7'b0100000, 7'b0, 7'b0, 7'b1110000);

        // Blink phase is 1 again; one-cycle reset mid-scan with enable held.
        repeat (5) @(negedge clock);
        reset = 1'b1;
        @(negedge clock);
        check_blank("rst+1", 1'b0);
        reset = 1'b0;
        @(negedge clock);
        check_blank("rel+1", 1'b0);
        @(negedge clock);
        check_blank("rel+2", 1'b1);
        check_frame("f12_rst", 7'b1110001, 7'b0100000, 7'b0, 7'b0, 7'b1110000);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
